// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the register file write port among writeback units.
// Define WB_ARB_STATS_EN to add per-requester grant and stall counters.
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR    = 5,
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 6
`ifdef WB_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ADDR-1:0]  req_rd,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     wb_valid,
    output logic [ADDR-1:0]          wb_reg,
    output logic [WIDTH-1:0]         wb_data,
    output logic [TAG_W-1:0]         wb_tag
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [NUM_REQ*CNT_W-1:0] stall_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] r_ptr;
    logic             r_valid;
    logic [ADDR-1:0]  r_reg;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;

    logic               w_found;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_fire;
    logic [ADDR-1:0]    w_rd;
    logic [WIDTH-1:0]   w_data;
    logic [TAG_W-1:0]   w_tag;

    // Scan from the pointer upwards (wrapping) and pick the first valid requester.
    always_comb begin
        logic [PTR_W:0] v_sum;
        w_found = 1'b0;
        w_idx   = '0;
        v_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (v_sum >= NREQ) begin
                v_sum = v_sum - NREQ;
            end
            if (!w_found && req_valid[v_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_sum[PTR_W-1:0];
            end
        end
    end

    // One-hot grant, suppressed during reset and flush.
    always_comb begin
        w_gnt = '0;
        if (rst && !flush && w_found) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign req_ready = w_gnt;
    assign w_fire    = |w_gnt;
    assign w_nxt     = (w_idx == LAST) ? '0 : w_idx + 1'b1;
    assign w_rd      = req_rd[int'(w_idx)*ADDR +: ADDR];
    assign w_data    = req_data[int'(w_idx)*WIDTH +: WIDTH];
    assign w_tag     = req_tag[int'(w_idx)*TAG_W +: TAG_W];

    // Register the winner's payload; idle and flush cycles drive zeros so nothing is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_reg   <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (flush) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_reg   <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (w_fire) begin
            r_ptr   <= w_nxt;
            r_valid <= 1'b1;
            r_reg   <= w_rd;
            r_data  <= w_data;
            r_tag   <= w_tag;
        end else begin
            r_valid <= 1'b0;
            r_reg   <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end
    end

    assign wb_valid = r_valid;
    assign wb_reg   = r_reg;
    assign wb_data  = r_data;
    assign wb_tag   = r_tag;

`ifdef WB_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CMAX = '1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [CNT_W-1:0] r_gcnt;
        logic [CNT_W-1:0] r_scnt;

        // Saturating grant and stall counters; only reset clears them.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_gcnt <= '0;
                r_scnt <= '0;
            end else begin
                if (w_gnt[gi] && r_gcnt != CMAX) begin
                    r_gcnt <= r_gcnt + 1'b1;
                end
                if (req_valid[gi] && !w_gnt[gi] && r_scnt != CMAX) begin
                    r_scnt <= r_scnt + 1'b1;
                end
            end
        end

        assign grant_cnt[gi*CNT_W +: CNT_W] = r_gcnt;
        assign stall_cnt[gi*CNT_W +: CNT_W] = r_scnt;
    end
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ functional-unit writeback requesters (ALU, MUL, DIV, LD/ST) in the superscalar back end.
- Grants at most one requester per cycle using round-robin order.
- Registers the winner's destination, data and tag.
- Drives the register file write port and the common-data-bus broadcast.
- The register file has no write enable and writes whenever its write address is nonzero, so this block forces the write address to 0 on idle cycles.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8)
- ADDR, 5, register address width
- WIDTH, 32, data width
- TAG_W, 6, ROB/reservation tag width
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush
- req_valid  input  NUM_REQ  per-requester writeback request
- req_rd  input  NUM_REQ*ADDR  flattened destination registers; requester i occupies bits [i*ADDR +: ADDR]
- req_data  input  NUM_REQ*WIDTH  flattened result data
- req_tag  input  NUM_REQ*TAG_W  flattened producer tags
- req_ready  output  NUM_REQ  one-hot grant, combinational
- wb_valid  output  1  broadcast valid, registered
- wb_reg  output  ADDR  register file write address, registered
- wb_data  output  WIDTH  register file write data, registered
- wb_tag  output  TAG_W  broadcast tag, registered
- grant_cnt  output  NUM_REQ*CNT_W  per-requester grant counters (only with WB_ARB_STATS_EN)
- stall_cnt  output  NUM_REQ*CNT_W  per-requester denied-cycle counters (only with WB_ARB_STATS_EN)

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_valid=0, wb_reg=0, wb_data=0, wb_tag=0.
  - Round-robin pointer rr_ptr=0.
  - Counters 0.
  - req_ready=0 while rst is low.
- Handshake:
  - A transfer happens on requester i when req_valid[i] & req_ready[i].
  - A requester must hold valid and its payload stable until granted.
  - req_ready is at most one-hot and never asserted without the matching req_valid.
- Arbitration:
  - Each cycle, scan indices rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - The first index with req_valid set wins.
- Pointer update:
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Latency: one cycle. On the cycle after a grant to i:
  - wb_valid=1, wb_data=data_i, wb_tag=tag_i.
  - wb_reg=rd_i.
- Idle cycle (no grant on the previous cycle): wb_valid=0 and wb_reg=0. wb_data and wb_tag are also driven 0, so the register file performs no write.
- rd=0 request:
  - Granted normally and broadcast with wb_valid=1 and wb_tag set, so dependents wake.
  - wb_reg=0, so no architectural write occurs.
- Flush (flush=1 on a cycle, highest priority):
  - req_ready=0 that cycle.
  - Next cycle wb_valid=0 and wb_reg=0.
  - rr_ptr <= 0.
  - A transfer granted on the cycle before the flush still appears on the outputs in the flush cycle.
- Back-to-back: a single requester with valid held continuously is granted every cycle, giving full throughput.
- Fairness: with all requesters valid, each is granted exactly once per NUM_REQ cycles.
- Reset mid-operation: outputs clear immediately. A pending grant is lost, and requesters must re-present.

Optional Feature:
- WB_ARB_STATS_EN defined:
  - grant_cnt[i] increments on each transfer by i.
  - stall_cnt[i] increments on each cycle where req_valid[i]=1 and req_ready[i]=0.
  - Both saturate at all-ones.
  - Both clear on reset only; flush does not clear them.
- WB_ARB_STATS_EN undefined:
  - grant_cnt and stall_cnt ports and their counter logic are absent.
  - Arbitration behaviour is identical.

Test Plan:
- Reset: hold rst=0 with req_valid=4'b1111 -> req_ready=0, wb_valid=0, wb_reg=0. Release rst -> first grant goes to requester 0.
- Single requester: req_valid=4'b0100, rd=5'd7, data=32'hDEADBEEF, tag=6'd9 -> req_ready=4'b0100 the same cycle. Next cycle wb_valid=1, wb_reg=7, wb_data=DEADBEEF, wb_tag=9.
- Round-robin: all four valid for 8 cycles, payloads held -> grant order 0,1,2,3,0,1,2,3, with exactly one req_ready bit set per cycle.
- rd=0: requester 1 with rd=0, data=32'h1234, tag=3 -> wb_valid=1, wb_tag=3, wb_reg=0, and register file contents unchanged.
- Flush: grant to 2 at cycle N, then flush=1 at N+1 with all requesters valid -> wb_valid=1 at N+1 (requester 2's result), req_ready=0 at N+1, wb_valid=0 at N+2, and requester 0 granted at N+2.
- Stats (WB_ARB_STATS_EN): requesters 0 and 3 valid for 10 cycles -> grant_cnt[0]=5, grant_cnt[3]=5, stall_cnt[0]=5, stall_cnt[3]=5.
